pong_ball_engine: RTL and testbench
===================================

PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

Interface
REQ-001 SHALL have parameter H_RES, 640, visible width in pixels.
REQ-002 SHALL have parameter V_RES, 480, visible height in pixels.
REQ-003 SHALL have parameter XW, 10, width of x coordinates; YW, 9, width of y coordinates.
REQ-004 SHALL have parameter BALL_SIZE, 8, ball edge length; PADDLE_W, 10; PADDLE_H, 60.
REQ-005 SHALL have parameter PADDLE1_X, 10, and PADDLE2_X, 620, paddle left edges.
REQ-006 SHALL have parameter STEP_X, 5, STEP_Y, 3, and STEP_X_MAX, 9, pixels per move.
REQ-007 SHALL have parameter FRAME_DIV, 1, frames per move; SERVE_FRAMES, 60, serve wait in frames.
REQ-008 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-009 i_rst  input  1  reset, synchronous, active-low.
REQ-010 o_active  input  1  high while a visible pixel is being scanned.
REQ-011 o_x  input  XW  current pixel x; o_y  input  YW  current pixel y.
REQ-012 pos_yBarra1, pos_yBarra2  input  YW  paddle top edges.
REQ-013 color  output  1  registered ball-pixel flag.
REQ-014 pointPlayer1, pointPlayer2  output  1  one-cycle score pulses.
REQ-015 ball_x  output  XW; ball_y  output  YW  current ball top-left corner.

Function
REQ-016 SHALL define frame_end as the cycle with o_x==H_RES-1 and o_y==V_RES-1; all motion is evaluated only on frame_end.
REQ-017 SHALL implement FSM SERVE -> PLAY -> SCORED -> SERVE.
REQ-018 SERVE: ball held at ((H_RES-BALL_SIZE)/2,(V_RES-BALL_SIZE)/2); after SERVE_FRAMES frame_ends -> PLAY.
REQ-019 PLAY: move counter counts frame_ends; every FRAME_DIV-th frame_end applies one move.
REQ-020 Move: x +/- cur_step_x, y +/- STEP_Y per direction bits dx (0 right, 1 left) and dy (0 down, 1 up).
REQ-021 Top wall: dy up and y<=STEP_Y -> y=0, dy=down.
REQ-022 Bottom wall: dy down and y+STEP_Y>=V_RES-BALL_SIZE -> y=V_RES-BALL_SIZE, dy=up.
REQ-023 Overlap(p): ball_y+BALL_SIZE>p and ball_y<p+PADDLE_H.
REQ-024 Paddle 1 hit: dx left, PADDLE1_X+PADDLE_W<=x<=PADDLE1_X+PADDLE_W+cur_step_x, overlap(pos_yBarra1) -> x=PADDLE1_X+PADDLE_W, dx=right.
REQ-025 Paddle 2 hit: dx right, x+BALL_SIZE<=PADDLE2_X<=x+BALL_SIZE+cur_step_x, overlap(pos_yBarra2) -> x=PADDLE2_X-BALL_SIZE, dx=left.
REQ-026 Miss right: dx right, no hit, x+BALL_SIZE+cur_step_x>=H_RES -> pointPlayer1=1 one cycle, -> SCORED.
REQ-027 Miss left: dx left, no hit, x<cur_step_x -> pointPlayer2=1 one cycle, -> SCORED.
REQ-028 Priority: miss > paddle hit > plain move on x; y wall logic applied in the same move independently, except a miss suppresses all position updates.
REQ-029 SCORED lasts one cycle: ball recentred, dx toward the scoring player's opponent's side (point1 -> dx=left, point2 -> dx=right), serve counter cleared, -> SERVE.
REQ-030 color SHALL be 1 the cycle after o_active=1, ball_x<=o_x<ball_x+BALL_SIZE, ball_y<=o_y<ball_y+BALL_SIZE; else 0 (including o_active=0).
REQ-031 All comparisons SHALL use XW+1/YW+1 bit arithmetic; no wrap-around.

Reset
REQ-032 i_rst=0 at a clk_in edge SHALL force SERVE, ball centred (316,236 at defaults), dx=right, dy=down, cur_step_x=STEP_X, counters 0, color=0, pointPlayer1=pointPlayer2=0; applies mid-PLAY and mid-pulse.

Configuration
REQ-033 With BALL_SPEEDUP_EN defined, each paddle hit SHALL set cur_step_x=min(cur_step_x+1,STEP_X_MAX), restored to STEP_X in SCORED; without it cur_step_x is constant STEP_X.

Verification
REQ-034 Reset, SERVE_FRAMES=2, FRAME_DIV=1: 2 frame_ends -> PLAY; 3rd frame_end -> ball (321,239).
REQ-035 Ball (400,471) dy down -> next move y=472, dy=up; at (400,2) dy up -> y=0, dy=down.
REQ-036 pos_yBarra2=200, ball (607,220) dx right -> x=612, dx=left, no point pulse; BALL_SPEEDUP_EN -> cur_step_x=6.
REQ-037 pos_yBarra2=0, ball (630,300) dx right -> pointPlayer1 high exactly one cycle, ball (316,236), dx=left, SERVE.
REQ-038 Ball (316,236): o_active=1,o_x=316,o_y=236 -> color=1 next cycle; o_x=324 -> 0; o_active=0 -> 0.
REQ-039 i_rst=0 during PLAY with ball at (500,100) -> next cycle SERVE, ball (316,236), all outputs 0.

Source files
------------

// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve/play/score FSM, wall and paddle bounces, ball pixel flag.
// Optional macro BALL_SPEEDUP_EN: each paddle hit speeds the ball up in x.
module pong_ball_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int XW           = 10,
  parameter int YW           = 9,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 60,
  parameter int PADDLE1_X    = 10,
  parameter int PADDLE2_X    = 620,
  parameter int STEP_X       = 5,
  parameter int STEP_Y       = 3,
  parameter int STEP_X_MAX   = 9,
  parameter int FRAME_DIV    = 1,
  parameter int SERVE_FRAMES = 60
) (
  input  logic          clk_in,
  input  logic          i_rst,
  input  logic          o_active,
  input  logic [XW-1:0] o_x,
  input  logic [YW-1:0] o_y,
  input  logic [YW-1:0] pos_yBarra1,
  input  logic [YW-1:0] pos_yBarra2,
  output logic          color,
  output logic          pointPlayer1,
  output logic          pointPlayer2,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y
);

  localparam int CW = 16;

  typedef logic [XW:0] xe_t;
  typedef logic [YW:0] ye_t;
  typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;

  localparam xe_t BSX = xe_t'(BALL_SIZE);
  localparam xe_t HX  = xe_t'(H_RES);
  localparam xe_t P1E = xe_t'(PADDLE1_X + PADDLE_W);
  localparam xe_t P2X = xe_t'(PADDLE2_X);
  localparam ye_t BSY = ye_t'(BALL_SIZE);
  localparam ye_t PHY = ye_t'(PADDLE_H);
  localparam ye_t SY  = ye_t'(STEP_Y);
  localparam ye_t YB  = ye_t'(V_RES - BALL_SIZE);

  localparam logic [XW-1:0] XC  = XW'((H_RES - BALL_SIZE) / 2);
  localparam logic [YW-1:0] YC  = YW'((V_RES - BALL_SIZE) / 2);
  localparam logic [XW-1:0] SX0 = XW'(STEP_X);
  localparam logic [XW-1:0] SXM = XW'(STEP_X_MAX);
  localparam logic [XW-1:0] XL  = XW'(H_RES - 1);
  localparam logic [YW-1:0] YL  = YW'(V_RES - 1);
  localparam logic [CW-1:0] SRV_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] MV_LAST  = CW'(FRAME_DIV - 1);

  state_t        state;
  logic          dx;
  logic          dy;
  logic [XW-1:0] step_x;
  logic [CW-1:0] srv_cnt;
  logic [CW-1:0] mv_cnt;

  logic frame_end;
  logic ov1, ov2, hit1, hit2;
  logic miss_r, miss_l;
  logic up_wall, dn_wall;
  logic pix;
  xe_t  bx, st, xo, nx;
  ye_t  by, yo, p1, p2, ny;
  logic ndx, ndy;
  logic [XW-1:0] step_up;

  assign frame_end = (o_x == XL) && (o_y == YL);

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign st = {1'b0, step_x};
  assign xo = {1'b0, o_x};
  assign yo = {1'b0, o_y};
  assign p1 = {1'b0, pos_yBarra1};
  assign p2 = {1'b0, pos_yBarra2};

  assign ov1 = (by + BSY > p1) && (by < p1 + PHY);
  assign ov2 = (by + BSY > p2) && (by < p2 + PHY);

  assign hit1 = dx && (P1E <= bx) && (bx <= P1E + st) && ov1;
  assign hit2 = !dx && (bx + BSX <= P2X)
             && (P2X <= bx + BSX + st) && ov2;

  assign miss_r = !dx && !hit2 && (bx + BSX + st >= HX);
  assign miss_l = dx && !hit1 && (bx < st);

  assign up_wall = dy && (by <= SY);
  assign dn_wall = !dy && (by + SY >= YB);

  assign pix = o_active
            && (xo >= bx) && (xo < bx + BSX)
            && (yo >= by) && (yo < by + BSY);

`ifdef BALL_SPEEDUP_EN
  assign step_up = (step_x < SXM) ? step_x + XW'(1) : step_x;
`else
  assign step_up = step_x;
`endif

  always_comb begin
    nx  = bx;
    ndx = dx;
    unique case (1'b1)
      hit1:          begin nx = P1E;       ndx = 1'b0; end
      hit2:          begin nx = P2X - BSX; ndx = 1'b1; end
      dx && !hit1:   nx = bx - st;
      !dx && !hit2:  nx = bx + st;
      default:       nx = bx;
    endcase
  end

  always_comb begin
    ny  = by;
    ndy = dy;
    unique case (1'b1)
      up_wall:          begin ny = '0; ndy = 1'b0; end
      dn_wall:          begin ny = YB; ndy = 1'b1; end
      dy && !up_wall:   ny = by - SY;
      !dy && !dn_wall:  ny = by + SY;
      default:          ny = by;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!i_rst) begin
      state        <= SERVE;
      ball_x       <= XC;
      ball_y       <= YC;
      dx           <= 1'b0;
      dy           <= 1'b0;
      step_x       <= SX0;
      srv_cnt      <= '0;
      mv_cnt       <= '0;
      color        <= 1'b0;
      pointPlayer1 <= 1'b0;
      pointPlayer2 <= 1'b0;
    end else begin
      color        <= pix;
      pointPlayer1 <= 1'b0;
      pointPlayer2 <= 1'b0;
      unique case (state)
        SERVE: begin
          if (frame_end) begin
            if (srv_cnt == SRV_LAST) begin
              state   <= PLAY;
              srv_cnt <= '0;
              mv_cnt  <= '0;
            end else begin
              srv_cnt <= srv_cnt + CW'(1);
            end
          end
        end
        PLAY: begin
          if (frame_end) begin
            if (mv_cnt == MV_LAST) begin
              mv_cnt <= '0;
              // a miss freezes the ball where it was
              if (miss_r) begin
                pointPlayer1 <= 1'b1;
                state        <= SCORED;
              end else if (miss_l) begin
                pointPlayer2 <= 1'b1;
                state        <= SCORED;
              end else begin
                ball_x <= nx[XW-1:0];
                ball_y <= ny[YW-1:0];
                dx     <= ndx;
                dy     <= ndy;
                if (hit1 || hit2) step_x <= step_up;
              end
            end else begin
              mv_cnt <= mv_cnt + CW'(1);
            end
          end
        end
        SCORED: begin
          ball_x  <= XC;
          ball_y  <= YC;
          dx      <= pointPlayer1;
          step_x  <= SX0;
          srv_cnt <= '0;
          state   <= SERVE;
        end
        default: state <= SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: directed scenarios plus randomized play
// checked against a frame-level game model.
module tb_pong_ball_engine;

  localparam int H = 640;
  localparam int V = 480;
  localparam int BS = 8;
  localparam int PH = 60;
  localparam int P1E = 20;
  localparam int P2X = 620;
  localparam int SX = 5;
  localparam int SY = 3;
  localparam int SXMAX = 9;
  localparam int SF = 2;
  localparam int FD = 1;
  localparam int CX = (H - BS) / 2;
  localparam int CY = (V - BS) / 2;
`ifdef BALL_SPEEDUP_EN
  localparam int SPD = 1;
`else
  localparam int SPD = 0;
`endif

  logic       clk_in;
  logic       i_rst;
  logic       o_active;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic [8:0] pos_yBarra1;
  logic [8:0] pos_yBarra2;
  logic       color;
  logic       pointPlayer1;
  logic       pointPlayer2;
  logic [9:0] ball_x;
  logic [8:0] ball_y;

  pong_ball_engine #(
    .SERVE_FRAMES(SF),
    .FRAME_DIV(FD)
  ) dut (
    .clk_in(clk_in),
    .i_rst(i_rst),
    .o_active(o_active),
    .o_x(o_x),
    .o_y(o_y),
    .pos_yBarra1(pos_yBarra1),
    .pos_yBarra2(pos_yBarra2),
    .color(color),
    .pointPlayer1(pointPlayer1),
    .pointPlayer2(pointPlayer2),
    .ball_x(ball_x),
    .ball_y(ball_y)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // game model: phase 0 waiting to serve, 1 in play, 2 point just scored
  int m_phase, m_bx, m_by, m_st, m_waited, m_frames;
  bit m_left, m_up, m_col, m_p1, m_p2;
  bit track;
  int g_p1, g_p2;

  function automatic int clamp_pad(input int y);
    return (y - 20 < 0) ? 0 : y - 20;
  endfunction

  task automatic step(input bit rst, input bit act, input int x, input int y);
    int p1, p2, st;
    int n_phase, n_bx, n_by, n_st, n_waited, n_frames;
    bit n_left, n_up, n_col, n_p1, n_p2;
    bit fe, ov1, ov2, hit1, hit2;
    if (track) begin
      p1 = clamp_pad(m_by);
      p2 = clamp_pad(m_by);
    end else begin
      p1 = g_p1;
      p2 = g_p2;
    end
    i_rst = rst;
    o_active = act;
    o_x = 10'(x);
    o_y = 9'(y);
    pos_yBarra1 = 9'(p1);
    pos_yBarra2 = 9'(p2);
    fe = (x == H - 1) && (y == V - 1);
    n_phase = m_phase; n_bx = m_bx; n_by = m_by; n_st = m_st;
    n_waited = m_waited; n_frames = m_frames;
    n_left = m_left; n_up = m_up;
    n_col = 0; n_p1 = 0; n_p2 = 0;
    if (!rst) begin
      n_phase = 0; n_bx = CX; n_by = CY; n_st = SX;
      n_waited = 0; n_frames = 0; n_left = 0; n_up = 0;
    end else begin
      n_col = act && x >= m_bx && x < m_bx + BS
                  && y >= m_by && y < m_by + BS;
      if (m_phase == 2) begin
        n_phase = 0; n_bx = CX; n_by = CY; n_st = SX;
        n_waited = 0; n_left = m_p1;
      end else if (fe && m_phase == 0) begin
        n_waited = m_waited + 1;
        if (n_waited == SF) begin
          n_phase = 1; n_waited = 0; n_frames = 0;
        end
      end else if (fe && m_phase == 1) begin
        n_frames = m_frames + 1;
        if (n_frames == FD) begin
          n_frames = 0;
          st = m_st;
          ov1 = (m_by + BS > p1) && (m_by < p1 + PH);
          ov2 = (m_by + BS > p2) && (m_by < p2 + PH);
          hit1 = m_left && m_bx >= P1E && m_bx <= P1E + st && ov1;
          hit2 = !m_left && m_bx + BS <= P2X && P2X <= m_bx + BS + st && ov2;
          if (!m_left && !hit2 && m_bx + BS + st >= H) begin
            n_p1 = 1; n_phase = 2;
          end else if (m_left && !hit1 && m_bx < st) begin
            n_p2 = 1; n_phase = 2;
          end else begin
            if (hit1) begin
              n_bx = P1E; n_left = 0;
            end else if (hit2) begin
              n_bx = P2X - BS; n_left = 1;
            end else begin
              n_bx = m_left ? m_bx - st : m_bx + st;
            end
            if ((hit1 || hit2) && SPD == 1)
              n_st = (st + 1 > SXMAX) ? SXMAX : st + 1;
            if (m_up) begin
              if (m_by <= SY) begin n_by = 0; n_up = 0; end
              else n_by = m_by - SY;
            end else begin
              if (m_by + SY >= V - BS) begin n_by = V - BS; n_up = 1; end
              else n_by = m_by + SY;
            end
          end
        end
      end
    end
    @(posedge clk_in);
    #1;
    m_phase = n_phase; m_bx = n_bx; m_by = n_by; m_st = n_st;
    m_waited = n_waited; m_frames = n_frames;
    m_left = n_left; m_up = n_up; m_col = n_col; m_p1 = n_p1; m_p2 = n_p2;
  endtask

  task automatic frame();
    step(1'b1, 1'b1, H - 1, V - 1);
  endtask

  task automatic test_reset();
    track = 0; g_p1 = 0; g_p2 = 0;
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 639, 479);
    n_cmp++;
    if (ball_x !== 10'd316 || ball_y !== 9'd236) begin
      n_bad++;
      $display("FAIL reset_pos: got (%0d,%0d) want (316,236)", ball_x, ball_y);
    end
    n_cmp++;
    if ({color, pointPlayer1, pointPlayer2} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_out: got %b want 000",
               {color, pointPlayer1, pointPlayer2});
    end
  endtask

  task automatic test_serve();
    step(1'b0, 1'b0, 0, 0);
    frame();
    step(1'b1, 1'b0, 5, 5);
    frame();
    n_cmp++;
    if (ball_x !== 10'd316 || ball_y !== 9'd236) begin
      n_bad++;
      $display("FAIL serve_hold: got (%0d,%0d) want (316,236)", ball_x, ball_y);
    end
    step(1'b1, 1'b0, 100, 479);
    frame();
    n_cmp++;
    if (ball_x !== 10'd321 || ball_y !== 9'd239) begin
      n_bad++;
      $display("FAIL serve_move: got (%0d,%0d) want (321,239)", ball_x, ball_y);
    end
  endtask

  task automatic test_color();
    int xs[6] = '{316, 324, 316, 323, 316, 315};
    int ys[6] = '{236, 236, 236, 243, 244, 236};
    bit as[6] = '{1, 1, 0, 1, 1, 1};
    bit ex[6] = '{1, 0, 0, 1, 0, 0};
    step(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, as[i], xs[i], ys[i]);
      n_cmp++;
      if (color !== ex[i]) begin
        n_bad++;
        $display("FAIL color_%0d: got %b want %b at (%0d,%0d) act %b",
                 i, color, ex[i], xs[i], ys[i], as[i]);
      end
    end
  endtask

  task automatic test_score();
    int n;
    track = 0; g_p1 = 0; g_p2 = 0;
    step(1'b0, 1'b0, 0, 0);
    n = 0;
    while (!m_p1 && n < 200) begin frame(); n++; end
    n_cmp++;
    if (pointPlayer1 !== 1'b1 || pointPlayer2 !== 1'b0 ||
        ball_x !== 10'd631 || ball_y !== 9'd425) begin
      n_bad++;
      $display("FAIL score_pulse: got p1 %b p2 %b (%0d,%0d) want 1 0 (631,425)",
               pointPlayer1, pointPlayer2, ball_x, ball_y);
    end
    step(1'b1, 1'b0, 3, 3);
    n_cmp++;
    if (pointPlayer1 !== 1'b0 || ball_x !== 10'd316 || ball_y !== 9'd236) begin
      n_bad++;
      $display("FAIL score_after: got p1 %b (%0d,%0d) want 0 (316,236)",
               pointPlayer1, ball_x, ball_y);
    end
    frame(); frame(); frame();
    n_cmp++;
    if (ball_x !== 10'd311 || ball_y !== 9'd239) begin
      n_bad++;
      $display("FAIL serve_left: got (%0d,%0d) want (311,239)", ball_x, ball_y);
    end
    n = 0;
    while (!m_p2 && n < 200) begin frame(); n++; end
    n_cmp++;
    if (pointPlayer2 !== 1'b1 || pointPlayer1 !== 1'b0) begin
      n_bad++;
      $display("FAIL score_p2: got p1 %b p2 %b want 0 1",
               pointPlayer1, pointPlayer2);
    end
    step(1'b0, 1'b1, 639, 479);
    n_cmp++;
    if ({color, pointPlayer1, pointPlayer2} !== 3'b000 ||
        ball_x !== 10'd316 || ball_y !== 9'd236) begin
      n_bad++;
      $display("FAIL reset_pulse: got %b (%0d,%0d) want 000 (316,236)",
               {color, pointPlayer1, pointPlayer2}, ball_x, ball_y);
    end
  endtask

  task automatic test_hit();
    int n;
    track = 1;
    step(1'b0, 1'b0, 0, 0);
    n = 0;
    while (!m_left && !m_p1 && n < 200) begin frame(); n++; end
    n_cmp++;
    if (ball_x !== 10'd612 || pointPlayer1 !== 1'b0 || pointPlayer2 !== 1'b0) begin
      n_bad++;
      $display("FAIL hit_p2: got x %0d p1 %b p2 %b want 612 0 0",
               ball_x, pointPlayer1, pointPlayer2);
    end
    frame();
    n_cmp++;
    if (ball_x !== 10'(612 - SX - SPD)) begin
      n_bad++;
      $display("FAIL hit_p2_step: got %0d want %0d", ball_x, 612 - SX - SPD);
    end
    n = 0;
    while (m_left && !m_p2 && n < 300) begin frame(); n++; end
    n_cmp++;
    if (ball_x !== 10'd20 || pointPlayer2 !== 1'b0) begin
      n_bad++;
      $display("FAIL hit_p1: got x %0d p2 %b want 20 0", ball_x, pointPlayer2);
    end
    n_cmp++;
    if (ball_x !== 10'(m_bx) || ball_y !== 9'(m_by)) begin
      n_bad++;
      $display("FAIL hit_model: got (%0d,%0d) want (%0d,%0d)",
               ball_x, ball_y, m_bx, m_by);
    end
    track = 0;
  endtask

  task automatic test_reset_mid();
    track = 0; g_p1 = 0; g_p2 = 0;
    step(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) frame();
    step(1'b0, 1'b1, 639, 479);
    n_cmp++;
    if ({color, pointPlayer1, pointPlayer2} !== 3'b000 ||
        ball_x !== 10'd316 || ball_y !== 9'd236) begin
      n_bad++;
      $display("FAIL reset_mid: got %b (%0d,%0d) want 000 (316,236)",
               {color, pointPlayer1, pointPlayer2}, ball_x, ball_y);
    end
    frame(); frame(); frame();
    n_cmp++;
    if (ball_x !== 10'd321 || ball_y !== 9'd239) begin
      n_bad++;
      $display("FAIL reset_dir: got (%0d,%0d) want (321,239)", ball_x, ball_y);
    end
  endtask

  task automatic test_random();
    int x, y, r;
    bit rst;
    track = 1;
    step(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6000; i++) begin
      if (m_p1 || m_p2) begin
        track = ($urandom_range(0, 3) != 0);
        g_p1 = $urandom_range(0, 420);
        g_p2 = $urandom_range(0, 420);
      end
      rst = ($urandom_range(0, 1499) != 0);
      r = $urandom_range(0, 5);
      if (r < 2) begin
        x = H - 1; y = V - 1;
      end else if (r < 4) begin
        x = m_bx + $urandom_range(0, 11) - 2;
        y = m_by + $urandom_range(0, 11) - 2;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        if (x > H - 2) x = H - 2;
      end else begin
        x = $urandom_range(0, H - 1);
        y = $urandom_range(0, V - 2);
      end
      step(rst, 1'($urandom_range(0, 3) != 0), x, y);
      n_cmp++;
      if (ball_x !== 10'(m_bx) || ball_y !== 9'(m_by) || color !== m_col ||
          pointPlayer1 !== m_p1 || pointPlayer2 !== m_p2) begin
        n_bad++;
        $display("FAIL random_%0d: got (%0d,%0d) c%b p%b%b want (%0d,%0d) c%b p%b%b",
                 i, ball_x, ball_y, color, pointPlayer1, pointPlayer2,
                 m_bx, m_by, m_col, m_p1, m_p2);
      end
    end
  endtask

  initial begin
    i_rst = 1'b0; o_active = 1'b0; o_x = '0; o_y = '0;
    pos_yBarra1 = '0; pos_yBarra2 = '0;
    track = 0; g_p1 = 0; g_p2 = 0;
    m_phase = 0; m_bx = CX; m_by = CY; m_st = SX; m_waited = 0;
    m_frames = 0; m_left = 0; m_up = 0; m_col = 0; m_p1 = 0; m_p2 = 0;
    test_reset();
    test_serve();
    test_color();
    test_score();
    test_hit();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
